// File: rtl/pc_branch_unit_pkg.sv
// Shared constants for the program-counter / branch unit:
// address width, default sequential step and FSM state encoding.
package pc_branch_unit_pkg;

    localparam int          ADDR_W          = 32;
    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

    typedef enum logic [1:0] {
        BOOT          = 2'd0,
        RUN           = 2'd1,
        HOLD          = 2'd2,
        HOLD_REDIRECT = 2'd3
    } pc_state_e;

endpackage : pc_branch_unit_pkg

// File: rtl/pc_target_adder.sv
// Combinational branch/jump target adder: sum = base + offset, modulo 2^32.
// Kept separate so the jump-and-link path can reuse it.
module pc_target_adder
    import pc_branch_unit_pkg::*;
(
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] sum
);

    // Wrap-around is intentional: the carry out is simply dropped.
    assign sum = base + offset;

endmodule : pc_target_adder

// File: rtl/pc_branch_unit.sv
// Program-counter owner: sequential increment, taken-branch/jump redirect,
// PC hold across instruction-memory stalls with a single queued redirect,
// one-cycle fetch flush on each applied redirect and a saturating
// redirect counter.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = PC_STEP_DEFAULT,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [ADDR_W-1:0]    BRANCH_OFFSET,
    input  logic                 JUMP,
    input  logic                 BRANCH,
    input  logic                 ZERO,
    input  logic                 BUSYWAIT,
    output logic [ADDR_W-1:0]    PC,
    output logic [ADDR_W-1:0]    PC_PLUS4,
    output logic                 FETCH_EN,
    output logic                 FLUSH,
    output logic [CNT_WIDTH-1:0] REDIRECT_CNT
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    pc_state_e             state_r;
    pc_state_e             state_next_s;
    logic [ADDR_W-1:0]     pc_r;
    logic [ADDR_W-1:0]     pc_next_s;
    logic [ADDR_W-1:0]     pc_plus4_s;
    logic [ADDR_W-1:0]     target_s;
    logic [ADDR_W-1:0]     pending_r;
    logic                  pend_load_s;
    logic                  flush_r;
    logic                  flush_next_s;
    logic                  redirect_s;
    logic                  fetch_en_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic                  taken_s;

    // JUMP and BRANCH together collapse into one redirect request.
    assign taken_s    = JUMP | (BRANCH & ZERO);
    assign pc_plus4_s = pc_r + PC_STEP;

    pc_target_adder u_target_adder (
        .base   (pc_plus4_s),
        .offset (BRANCH_OFFSET),
        .sum    (target_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; RUN and HOLD share transitions, only the stall
    // without a request decides whether we sit in HOLD.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BOOT: begin
                state_next_s = RUN;
            end
            RUN, HOLD: begin
                if (BUSYWAIT) begin
                    if (taken_s) begin
                        state_next_s = HOLD_REDIRECT;
                    end else begin
                        state_next_s = HOLD;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            HOLD_REDIRECT: begin
                if (BUSYWAIT) begin
                    state_next_s = HOLD_REDIRECT;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = BOOT;
            end
        endcase
    end

    // Datapath controls: next PC, flush request, counter bump, pending latch.
    always_comb begin
        pc_next_s    = pc_r;
        flush_next_s = 1'b0;
        redirect_s   = 1'b0;
        pend_load_s  = 1'b0;
        case (state_r)
            BOOT: begin
                pc_next_s = pc_r;
            end
            RUN, HOLD: begin
                if (BUSYWAIT) begin
                    pend_load_s = taken_s;
                end else if (taken_s) begin
                    pc_next_s    = target_s;
                    flush_next_s = 1'b1;
                    redirect_s   = 1'b1;
                end else begin
                    pc_next_s = pc_plus4_s;
                end
            end
            HOLD_REDIRECT: begin
                // The first latched target wins; live inputs are ignored.
                if (BUSYWAIT) begin
                    pc_next_s = pc_r;
                end else begin
                    pc_next_s    = pending_r;
                    flush_next_s = 1'b1;
                    redirect_s   = 1'b1;
                end
            end
            default: begin
                pc_next_s = pc_r;
            end
        endcase
    end

    // PC register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Redirect target queued while instruction memory is stalled.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pending_r <= {ADDR_W{1'b0}};
        end else if (pend_load_s) begin
            pending_r <= target_s;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Registered flush and fetch-enable; both line up with the PC they describe.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            flush_r    <= 1'b0;
            fetch_en_r <= 1'b0;
        end else begin
            flush_r    <= flush_next_s;
            fetch_en_r <= (state_next_s != BOOT);
        end
    end

    // Saturating count of applied redirects.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (redirect_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign PC           = pc_r;
    assign PC_PLUS4     = pc_plus4_s;
    assign FETCH_EN     = fetch_en_r;
    assign FLUSH        = flush_r;
    assign REDIRECT_CNT = cnt_r;

endmodule : pc_branch_unit

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit. A 2-bit redirect counter is used so
// saturation is reached within a short run. Expected values are hand-computed.
module tb_pc_branch_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] BRANCH_OFFSET;
    logic        JUMP;
    logic        BRANCH;
    logic        ZERO;
    logic        BUSYWAIT;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        FETCH_EN;
    logic        FLUSH;
    logic [1:0]  REDIRECT_CNT;

    int vec_cnt = 0;
    int err_cnt = 0;

    pc_branch_unit #(
        .RESET_PC  (32'h0000_0000),
        .PC_STEP   (32'd4),
        .CNT_WIDTH (2)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BRANCH_OFFSET (BRANCH_OFFSET),
        .JUMP          (JUMP),
        .BRANCH        (BRANCH),
        .ZERO          (ZERO),
        .BUSYWAIT      (BUSYWAIT),
        .PC            (PC),
        .PC_PLUS4      (PC_PLUS4),
        .FETCH_EN      (FETCH_EN),
        .FLUSH         (FLUSH),
        .REDIRECT_CNT  (REDIRECT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic j, input logic b, input logic z,
                         input logic bw, input logic [31:0] off);
        JUMP          = j;
        BRANCH        = b;
        ZERO          = z;
        BUSYWAIT      = bw;
        BRANCH_OFFSET = off;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Check PC, FLUSH and counter in one go.
    task automatic check_state(input string tag, input logic [31:0] pc_exp,
                               input logic fl_exp, input logic [1:0] cnt_exp);
        check_eq({tag, ".pc"},    PC,                   pc_exp);
        check_eq({tag, ".flush"}, {31'd0, FLUSH},        {31'd0, fl_exp});
        check_eq({tag, ".cnt"},   {30'd0, REDIRECT_CNT}, {30'd0, cnt_exp});
    endtask

    initial begin
        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // 1. Reset and boot
        tick();
        tick();
        check_state("rst", 32'h0, 1'b0, 2'd0);
        check_eq("rst.fe", {31'd0, FETCH_EN}, 32'd0);
        RESET = 1'b1;
        // BOOT ignores a redirect request
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        tick();
        check_state("boot", 32'h0, 1'b0, 2'd0);
        check_eq("boot.fe", {31'd0, FETCH_EN}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); check_eq("seq4",  PC, 32'h4);
        tick(); check_eq("seq8",  PC, 32'h8);
        tick(); check_eq("seq12", PC, 32'hC);
        tick(); check_eq("seq16", PC, 32'h10);
        check_eq("pc_plus4", PC_PLUS4, 32'h14);

        // 2. Taken BEQ at 0x10: 0x14 + 0x20 = 0x34
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h20);
        tick(); check_state("beq_taken", 32'h34, 1'b1, 2'd1);
        // Not-taken BEQ: sequential
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h20);
        tick(); check_state("beq_nt", 32'h38, 1'b0, 2'd1);

        // 3. Backward jump at 0x40: 0x44 - 0x10 = 0x34
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); check_eq("seq3c", PC, 32'h3C);
        tick(); check_eq("seq40", PC, 32'h40);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0);
        tick(); check_state("jmp_back", 32'h34, 1'b1, 2'd2);
        // JUMP+BRANCH together, back-to-back: 0x38 + 0xC = 0x44, count +1 only
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hC);
        tick(); check_state("jmp_beq", 32'h44, 1'b1, 2'd3);

        // 4. Reach 0x20: 0x48 - 0x28 = 0x20 (count saturated at 3)
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFD8);
        tick(); check_state("to20", 32'h20, 1'b1, 2'd3);
        // Stall: first target 0x24 + 0x8 = 0x2C latched
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h8);
        tick(); check_state("stall1", 32'h20, 1'b0, 2'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        tick(); check_state("stall2", 32'h20, 1'b0, 2'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(); check_state("stall3", 32'h20, 1'b0, 2'd3);
        check_eq("stall.fe", {31'd0, FETCH_EN}, 32'd1);
        // Release: live jump ignored, pending target applied
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h400);
        tick(); check_state("stall_rel", 32'h2C, 1'b1, 2'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); check_state("post_rel", 32'h30, 1'b0, 2'd3);
        // Plain HOLD, then redirect as the stall drops: 0x34 + 0x10 = 0x44
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(); check_state("hold", 32'h30, 1'b0, 2'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
        tick(); check_state("hold_jmp", 32'h44, 1'b1, 2'd3);

        // 5. Wrap: 0x48 + 0xFFFFFFB4 = 0xFFFFFFFC, then sequential to 0
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFB4);
        tick(); check_state("to_top", 32'hFFFF_FFFC, 1'b1, 2'd3);
        check_eq("pc_plus4_wrap", PC_PLUS4, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); check_state("wrap", 32'h0, 1'b0, 2'd3);

        // 6. Reset mid-stall: go to 0x40, latch pending 0x44 + 0x1BC = 0x200
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h3C);
        tick(); check_eq("to40", PC, 32'h40);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h1BC);
        tick(); check_state("pend200", 32'h40, 1'b0, 2'd3);
        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick(); check_state("rst_mid", 32'h0, 1'b0, 2'd0);
        check_eq("rst_mid.fe", {31'd0, FETCH_EN}, 32'd0);
        RESET = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); check_state("reboot", 32'h0, 1'b0, 2'd0);
        tick(); check_state("reboot_seq", 32'h4, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_pc_branch_unit

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter owner for the single-issue ARM-style core.
- Consumes the 32-bit sign-extended, word-scaled branch offset from the decode stage and produces the next fetch address.
- Selects between sequential increment, taken-branch target and unconditional-jump target.
- Holds the PC across instruction-memory stalls, queues any redirect requested during a stall, and flags a one-cycle fetch flush on every redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential instruction.
- CNT_WIDTH, 16, width of the taken-redirect performance counter.

Ports:
- CLK  input  1  core clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-low reset.
- BRANCH_OFFSET  input  32  sign-extended, left-shifted-by-2 byte displacement.
- JUMP  input  1  unconditional redirect request.
- BRANCH  input  1  conditional (BEQ) redirect request.
- ZERO  input  1  ALU zero flag qualifying BRANCH.
- BUSYWAIT  input  1  instruction memory stall; PC must hold while high.
- PC  output  32  current fetch address, registered.
- PC_PLUS4  output  32  PC + PC_STEP, combinational from PC.
- FETCH_EN  output  1  high when PC is valid for fetch.
- FLUSH  output  1  one-cycle pulse the cycle after PC is loaded with a redirect target.
- REDIRECT_CNT  output  CNT_WIDTH  count of applied redirects, saturating.

Behaviour:
- Reset: RESET low at a rising edge sets the following. RESET overrides everything, including mid-stall and a pending redirect.
  - PC=RESET_PC
  - state=BOOT
  - FETCH_EN=0
  - FLUSH=0
  - REDIRECT_CNT=0
  - pending target cleared
- taken = JUMP | (BRANCH & ZERO). JUMP and BRANCH together resolve as one redirect; no double count.
- target = PC_PLUS4 + BRANCH_OFFSET, modulo 2^32. Wrap-around is silent, with no exception. PC + PC_STEP also wraps.
- States:
  - BOOT: FETCH_EN=0, PC held. Next cycle goes to RUN unconditionally. Redirect inputs are ignored.
  - RUN: FETCH_EN=1.
    - BUSYWAIT=0 and taken: PC<=target, FLUSH<=1, counter+1.
    - BUSYWAIT=0 and not taken: PC<=PC+PC_STEP.
    - BUSYWAIT=1 and not taken: PC held, go to HOLD.
    - BUSYWAIT=1 and taken: PC held, pending<=target, go to HOLD_REDIRECT.
  - HOLD: PC held; FETCH_EN stays 1.
    - BUSYWAIT=1 and taken: latch target, go to HOLD_REDIRECT.
    - BUSYWAIT=0 and taken: PC<=target, FLUSH<=1, counter+1, back to RUN.
    - BUSYWAIT=0 and not taken: PC<=PC+PC_STEP, back to RUN.
  - HOLD_REDIRECT: PC held.
    - Further taken requests are ignored. The first latched target wins.
    - When BUSYWAIT falls: PC<=pending, FLUSH<=1, counter+1, go to RUN. Inputs in that cycle are ignored.
- FLUSH is registered. It is high for exactly one cycle, coincident with the first cycle PC shows the new target. Back-to-back redirects give FLUSH high on consecutive cycles.
- REDIRECT_CNT saturates at all-ones and never wraps.
- Latency: a redirect with no stall is visible on PC one cycle after the request edge.

Decomposition:
- Shared package holds:
  - state encoding constants: BOOT=2'd0, RUN=2'd1, HOLD=2'd2, HOLD_REDIRECT=2'd3
  - PC_STEP default
  - the 32-bit address width constant
- One sub-module is natural: pc_target_adder, a combinational 32-bit PC_PLUS4 + BRANCH_OFFSET adder, reusable by the jump-and-link path.
- The FSM, PC register and counter stay in the top module.

Test Plan:
1. Reset and boot: RESET=0 for 2 cycles, then 1 → PC=0, FETCH_EN=0 for one cycle, then PC=0,4,8,12 on successive cycles.
2. Taken BEQ: at PC=0x10, BRANCH=1, ZERO=1, OFFSET=0x0000_0020 → next PC=0x34, FLUSH=1 for one cycle, REDIRECT_CNT=1. With ZERO=0 → next PC=0x14, FLUSH=0.
3. Backward jump: at PC=0x40, JUMP=1, OFFSET=0xFFFF_FFF0 → PC=0x34. JUMP and BRANCH both high → single redirect, count +1.
4. Stall with redirect: at PC=0x20, BUSYWAIT=1 for 3 cycles, JUMP=1 with OFFSET=0x8 in the first stall cycle and OFFSET=0x100 in the second → PC held at 0x20 for the stall, then 0x2C, FLUSH on that cycle.
5. Wrap and saturation: PC=0xFFFF_FFFC with no branch → PC=0x0. With CNT_WIDTH=2, four redirects → REDIRECT_CNT stays 3.
6. Reset mid-stall: in HOLD_REDIRECT with pending 0x200, assert RESET=0 → PC=RESET_PC, FLUSH=0, count 0, pending discarded after release.
